pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
- Central stall/flush controller for the 5-stage core; consumes hazard requests (load-use stop from the forwarding unit, branch/jump redirect from E, multi-cycle MDU busy, data-bus wait) and drives per-stage hold/flush and the PC load.
- Arbitrates simultaneous requests by fixed priority and guarantees exactly one load-use bubble per hazard.
- Keeps saturating performance counters and a data-bus stall watchdog.

Parameters:
ADDR_W, 32, width of PC / jump target
CNT_W, 32, width of performance counters
MEM_TIMEOUT, 255, consecutive mem_wait cycles before bus_timeout_o sets (>=1)

Ports:
clk  input  1  core clock
rst_n  input  1  synchronous active-low reset
pc_stopFlag_i  input  1  load-use hazard request from D/E comparison
jump_flag_i  input  1  taken branch/jump resolved in E
jump_addr_i  input  ADDR_W  redirect target
mdu_busy_i  input  1  multi-cycle mul/div occupying E, result not ready
mem_wait_i  input  1  data bus not ready for access in M
pc_hold_o  output  1  PC keeps value
fd_hold_o  output  1  F/D register keeps value
de_hold_o  output  1  D/E register keeps value
em_hold_o  output  1  E/M register keeps value
mw_hold_o  output  1  M/W register keeps value
fd_flush_o  output  1  F/D loads NOP
de_flush_o  output  1  D/E loads NOP
em_flush_o  output  1  E/M loads NOP
pc_load_o  output  1  PC loads pc_target_o
pc_target_o  output  ADDR_W  redirect target
stall_cnt_o  output  CNT_W  cycles with pc_hold_o=1
flush_cnt_o  output  CNT_W  redirects taken
bus_timeout_o  output  1  sticky watchdog flag

Behaviour:
- Clock clk, reset synchronous active-low on rst_n. Reset: state=RUN, counters=0, watchdog=0, bus_timeout_o=0.
- Control outputs are combinational from state and inputs (same-cycle stall). All forced 0 while rst_n=0; pc_target_o=0 whenever pc_load_o=0.
- States: RUN, BUBBLE, STALL_MEM, STALL_MDU. Same decode in every state except the BUBBLE rule below.
- Priority (highest first), one action per cycle:
  1. mem_wait_i: all five holds=1, no flush, no pc_load; next STALL_MEM.
  2. mdu_busy_i: pc/fd/de holds=1, em_flush_o=1, em_hold_o=0, mw_hold_o=0; next STALL_MDU.
  3. jump_flag_i: pc_load_o=1, pc_target_o=jump_addr_i, fd_flush_o=1, de_flush_o=1, no holds; a coincident pc_stopFlag_i is ignored; next RUN.
  4. pc_stopFlag_i (state != BUBBLE): pc_hold_o=1, fd_hold_o=1, de_flush_o=1; next BUBBLE.
  5. None of the above: all outputs 0; next RUN.
- BUBBLE lasts one cycle. pc_stopFlag_i is ignored there, since the load is now in M and forwarding covers it. This guarantees at most one bubble and no livelock. Rules 1–3 still apply in BUBBLE.
- A jump deferred by rule 1 or 2 is not latched. The E instruction is frozen, so jump_flag_i stays asserted and is taken on release.
- stall_cnt_o increments on every cycle with pc_hold_o=1.
- flush_cnt_o increments on every cycle with pc_load_o=1.
- Both counters saturate at 2^CNT_W-1 and never wrap.
- Watchdog:
  - Counts consecutive mem_wait_i cycles; clears on any cycle with mem_wait_i=0.
  - On the cycle the count reaches MEM_TIMEOUT, bus_timeout_o goes 1 at the next edge and stays 1 until reset.
  - The stall continues regardless; the counter saturates at MEM_TIMEOUT.
- Reset mid-stall: the next edge with rst_n=0 returns to RUN. Outputs are already 0 during the low cycle.

Test Plan:
- Load-use: pc_stopFlag_i high for 2 consecutive cycles. Cycle 0: pc_hold/fd_hold/de_flush=1. Cycle 1 (BUBBLE): all 0. stall_cnt_o=1.
- Jump + load-use same cycle, jump_addr_i=0x0000_1000. pc_load_o=1, pc_target_o=0x1000, fd/de_flush=1, pc_hold_o=0. flush_cnt_o=1, next state RUN.
- mem_wait_i high 3 cycles with jump_flag_i held high. Three cycles all holds=1 with pc_load_o=0. 4th cycle pc_load_o=1. stall_cnt_o=3.
- mdu_busy_i high 4 cycles. Each cycle pc/fd/de hold=1, em_flush_o=1, em_hold_o=0. Then all 0 when busy drops.
- MEM_TIMEOUT=4, mem_wait_i high 6 cycles. bus_timeout_o=1 from the edge after the 4th cycle. It stays 1 after mem_wait_i drops and clears only on rst_n=0.
- CNT_W=4, hold pc_stopFlag_i pattern to force 20 stalls. stall_cnt_o saturates at 15. rst_n low one cycle mid-stall: all outputs 0, counters 0, state RUN.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush controller for the 5-stage core.
// Turns hazard requests (load-use, jump redirect, MDU busy, data-bus wait)
// into per-stage hold/flush strobes and the PC load, one action per cycle
// by fixed priority. Also keeps saturating stall/redirect counters and a
// sticky data-bus watchdog.
//
// Handshake note: there is no valid/ready pairing here. Every request input
// is a level that is sampled combinationally each cycle, and every control
// output is a same-cycle response to the current state and request levels.
// A request that loses arbitration is not remembered; the requester keeps
// it asserted until it is served.
module pipe_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_stopFlag_i,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              mdu_busy_i,
    input  logic              mem_wait_i,
    output logic              pc_hold_o,
    output logic              fd_hold_o,
    output logic              de_hold_o,
    output logic              em_hold_o,
    output logic              mw_hold_o,
    output logic              fd_flush_o,
    output logic              de_flush_o,
    output logic              em_flush_o,
    output logic              pc_load_o,
    output logic [ADDR_W-1:0] pc_target_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o,
    output logic              bus_timeout_o
);

    // Watchdog counter only needs to reach MEM_TIMEOUT, where it saturates.
    localparam int              WD_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Only BUBBLE changes the decode; the stall states exist so the current
    // reason for a stall is visible when debugging.
    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_BUBBLE    = 2'd1,
        ST_STALL_MEM = 2'd2,
        ST_STALL_MDU = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Debug view of the FSM for checkers and waveform viewers.
    logic [1:0] state_dbg;
    assign state_dbg = state_q;

    // Combinational control strobes before they reach the ports.
    logic              pc_hold, fd_hold, de_hold, em_hold, mw_hold;
    logic              fd_flush, de_flush, em_flush;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_target;

    // Counter and watchdog registers.
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic             timeout_q, timeout_d;

    // FSM state register; a low reset on any edge returns to RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority arbitration: mem wait > MDU busy > jump > load-use > idle.
    always_comb begin
        state_d   = ST_RUN;
        pc_hold   = 1'b0;
        fd_hold   = 1'b0;
        de_hold   = 1'b0;
        em_hold   = 1'b0;
        mw_hold   = 1'b0;
        fd_flush  = 1'b0;
        de_flush  = 1'b0;
        em_flush  = 1'b0;
        pc_load   = 1'b0;
        pc_target = '0;
        if (rst_n) begin
            if (mem_wait_i) begin
                // Whole pipe freezes until the data bus answers.
                pc_hold = 1'b1;
                fd_hold = 1'b1;
                de_hold = 1'b1;
                em_hold = 1'b1;
                mw_hold = 1'b1;
                state_d = ST_STALL_MEM;
            end else if (mdu_busy_i) begin
                // Front end and E freeze; a NOP drains into M so W keeps moving.
                pc_hold  = 1'b1;
                fd_hold  = 1'b1;
                de_hold  = 1'b1;
                em_flush = 1'b1;
                state_d  = ST_STALL_MDU;
            end else if (jump_flag_i) begin
                // Redirect wins over load-use: the dependent instruction is
                // on the wrong path and gets flushed anyway.
                pc_load   = 1'b1;
                pc_target = jump_addr_i;
                fd_flush  = 1'b1;
                de_flush  = 1'b1;
                state_d   = ST_RUN;
            end else if (pc_stopFlag_i && (state_q != ST_BUBBLE)) begin
                // One bubble: hold the front end, insert NOP into E.
                pc_hold  = 1'b1;
                fd_hold  = 1'b1;
                de_flush = 1'b1;
                state_d  = ST_BUBBLE;
            end else begin
                // Idle, or a repeated load-use request right after its bubble;
                // the load is now in M and forwarding covers the dependency.
                state_d = ST_RUN;
            end
        end
    end

    // Saturating counter and watchdog next-state logic.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        wd_cnt_d    = '0;
        timeout_d   = timeout_q;
        if (pc_hold && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (pc_load && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
        if (mem_wait_i) begin
            if (wd_cnt_q == WD_MAX) begin
                wd_cnt_d = WD_MAX;
            end else begin
                wd_cnt_d = wd_cnt_q + WD_W'(1);
            end
            // wd_cnt_q counts earlier wait cycles, so this cycle is number
            // wd_cnt_q+1; reaching MEM_TIMEOUT sets the flag at this edge.
            if (wd_cnt_q >= (WD_MAX - WD_W'(1))) begin
                timeout_d = 1'b1;
            end
        end
    end

    // Counter and watchdog registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wd_cnt_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign pc_hold_o     = pc_hold;
    assign fd_hold_o     = fd_hold;
    assign de_hold_o     = de_hold;
    assign em_hold_o     = em_hold;
    assign mw_hold_o     = mw_hold;
    assign fd_flush_o    = fd_flush;
    assign de_flush_o    = de_flush;
    assign em_flush_o    = em_flush;
    assign pc_load_o     = pc_load;
    assign pc_target_o   = pc_target;
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;
    assign bus_timeout_o = timeout_q;

endmodule
